// File: rtl/data_mem_responder_if.sv
// Load/store request/response bus between a load/store unit (master)
// and the data memory responder (slave).
interface data_mem_responder_if;
   logic        cs;
   logic        rd_wr;
   logic [3:0]  mask;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ready;
   logic [31:0] rdata;
   logic        resp_valid;
   logic        err;

   modport master (
      output cs, rd_wr, mask, addr, wdata,
      input  ready, rdata, resp_valid, err
   );

   modport slave (
      input  cs, rd_wr, mask, addr, wdata,
      output ready, rdata, resp_valid, err
   );
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory responder.
// Accepts one request at a time while idle, waits LATENCY edges, performs
// the access on the final edge and raises resp_valid for one cycle.
// Memory is four byte-wide arrays with registered reads; it is never reset.
// Optional macro DMEM_ERR_EN: flags misaligned / out-of-range requests on err,
// suppresses errored writes and returns zero for errored reads. Without it,
// err is tied low, addr[1:0] is ignored and the word index wraps.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   data_mem_responder_if.slave  bus
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = 4;
   localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          accept;
   logic          access;

   logic [31:0]   addr_q;
   logic          wr_q;
   logic [3:0]    mask_q;
   logic [31:0]   wdata_q;

   logic [AW-1:0] idx;
   logic [31:0]   mem_rd;
   logic          req_err;
   logic          resp_err;
   logic          resp_valid;

   assign idx = addr_q[AW+1:2];

   // State and latency counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic: accept in IDLE, count down in WAIT, respond once in RESP
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      access  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.cs) begin
               accept  = 1'b1;
               cnt_d   = CNT_LOAD;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               access  = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Request fields are captured only on acceptance, so later input changes are ignored
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q  <= '0;
         wr_q    <= 1'b0;
         mask_q  <= '0;
         wdata_q <= '0;
      end else if (accept) begin
         addr_q  <= bus.addr;
         wr_q    <= bus.rd_wr;
         mask_q  <= bus.mask;
         wdata_q <= bus.wdata;
      end
   end

   // One byte-wide RAM per lane: masked write, full-word registered read
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] mem_q [DEPTH_WORDS];
         logic [7:0] rd_q;

         always_ff @(posedge clk) begin
            if (access && wr_q && mask_q[gi] && !req_err) begin
               mem_q[idx] <= wdata_q[8*gi +: 8];
            end
            if (access && !wr_q) begin
               rd_q <= mem_q[idx];
            end
         end

         assign mem_rd[8*gi +: 8] = rd_q;
      end
   endgenerate

`ifdef DMEM_ERR_EN
   logic misaligned;
   logic out_of_range;
   logic err_q;

   assign misaligned   = ((mask_q == 4'b1111) && (addr_q[1:0] != 2'b00)) ||
                         (((mask_q == 4'b0011) || (mask_q == 4'b1100)) && addr_q[0]);
   assign out_of_range = |addr_q[31:AW+2];
   assign req_err      = misaligned | out_of_range;

   // Error status is decided at access time and held through the response cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_q <= 1'b0;
      end else if (access) begin
         err_q <= req_err;
      end
   end

   assign resp_err = err_q;
   assign bus.err  = resp_valid & err_q;
`else
   logic unused_addr_bits;

   // Upper address bits wrap and the byte offset is ignored in this build
   assign unused_addr_bits = ^{addr_q[31:AW+2], addr_q[1:0]};
   assign req_err  = 1'b0;
   assign resp_err = 1'b0;
   assign bus.err  = 1'b0;
`endif

   assign resp_valid     = (state_q == RESP);
   assign bus.ready      = (state_q == IDLE);
   assign bus.resp_valid = resp_valid;
   // Write responses and errored reads return zero; rdata is zero outside RESP
   assign bus.rdata      = (resp_valid && !wr_q && !resp_err) ? mem_rd : '0;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed requests against an edge-counting
// behavioural model (byte-level memory, acceptance/response timing), a
// per-cycle compare process, and literal expectations for each scenario.
module tb_data_mem_responder;
   localparam int DEPTH = 256;
   localparam int LAT   = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   data_mem_responder_if bus0();
   data_mem_responder_if bus1();

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut0 (
      .clk(clk), .reset(reset), .bus(bus0)
   );
   data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_to(input string name);
      checks++;
      failures++;
      $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0]  m_byte  [DEPTH][4];
   bit   [3:0]  m_known [DEPTH];
   bit          m_active, m_resp, m_wr, m_exp_err;
   int          m_cyc, m_acc, n_acc, rv_count;
   logic [3:0]  m_mask;
   logic [31:0] m_addr, m_wdata, m_exp_rdata, m_exp_kmask;

   function automatic bit model_err(input logic [31:0] a, input logic [3:0] m);
`ifdef DMEM_ERR_EN
      bit mis;
      mis = ((m == 4'hF) && (a % 4 != 0)) || (((m == 4'h3) || (m == 4'hC)) && (a % 2 != 0));
      return mis || (a >= 32'(4 * DEPTH));
`else
      return (a === 32'hx) && (m === 4'hx);
`endif
   endfunction

   // Edge counting: accepted on edge A, response visible after edge A+LAT, idle after A+LAT+1
   always @(posedge clk or posedge reset) begin
      bit was_idle;
      int w;
      bit e;
      if (reset) begin
         m_active = 1'b0;
         m_resp   = 1'b0;
      end else begin
         was_idle = !m_active;
         m_cyc++;
         m_resp = 1'b0;
         if (m_active && m_cyc == m_acc + LAT) begin
            w = int'((m_addr / 4) % DEPTH);
            e = model_err(m_addr, m_mask);
            m_resp      = 1'b1;
            m_exp_err   = e;
            m_exp_rdata = '0;
            m_exp_kmask = '1;
            for (int b = 0; b < 4; b++) begin
               if (m_wr && !e && m_mask[b]) begin
                  m_byte[w][b]  = m_wdata[8*b +: 8];
                  m_known[w][b] = 1'b1;
               end
               if (!m_wr && !e) begin
                  m_exp_rdata[8*b +: 8] = m_byte[w][b];
                  m_exp_kmask[8*b +: 8] = m_known[w][b] ? 8'hFF : 8'h00;
               end
            end
         end
         if (m_active && m_cyc == m_acc + LAT + 1) m_active = 1'b0;
         if (was_idle && bus0.cs) begin
            m_wr     = bus0.rd_wr;
            m_mask   = bus0.mask;
            m_addr   = bus0.addr;
            m_wdata  = bus0.wdata;
            m_acc    = m_cyc;
            m_active = 1'b1;
            n_acc++;
         end
      end
   end

   // Per-cycle comparison of dut0 against the model
   always @(negedge clk) begin
      if (reset) begin
         chk("rst_ready", 32'(bus0.ready), 32'd1);
         chk("rst_resp_valid", 32'(bus0.resp_valid), 32'd0);
         chk("rst_rdata", bus0.rdata, 32'd0);
         chk("rst_err", 32'(bus0.err), 32'd0);
      end else begin
         chk("ready", 32'(bus0.ready), 32'(!m_active));
         chk("resp_valid", 32'(bus0.resp_valid), 32'(m_resp));
         if (m_resp) begin
            chk("rdata", bus0.rdata & m_exp_kmask, m_exp_rdata & m_exp_kmask);
            chk("err", 32'(bus0.err), 32'(m_exp_err));
         end
         if (bus0.resp_valid) rv_count++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic do_req(input bit wr, input logic [3:0] mask, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic err, output int lat);
      int base;
      bit got;
      rdata = '0;
      err   = 1'b0;
      lat   = 0;
      @(negedge clk);
      bus0.cs = 1'b1; bus0.rd_wr = wr; bus0.mask = mask; bus0.addr = addr; bus0.wdata = wdata;
      base = n_acc;
      got  = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clk); #1;
         if (n_acc != base) got = 1'b1;
      end
      bus0.cs = 1'b0;
      if (!got) fail_to("accept_timeout");
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clk); #1;
         lat++;
         if (bus0.resp_valid) begin
            got   = 1'b1;
            rdata = bus0.rdata;
            err   = bus0.err;
         end
      end
      if (!got) fail_to("resp_timeout");
      @(posedge clk); #1;
   endtask

   task automatic do_req1(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata);
      @(negedge clk);
      chk("l1_ready_idle", 32'(bus1.ready), 32'd1);
      bus1.cs = 1'b1; bus1.rd_wr = wr; bus1.mask = 4'hF; bus1.addr = addr; bus1.wdata = wdata;
      @(posedge clk); #1;
      bus1.cs = 1'b0;
      chk("l1_ready_busy", 32'(bus1.ready), 32'd0);
      chk("l1_resp_early", 32'(bus1.resp_valid), 32'd0);
      @(posedge clk); #1;
      chk("l1_resp_valid", 32'(bus1.resp_valid), 32'd1);
      chk("l1_ready_in_resp", 32'(bus1.ready), 32'd0);
      rdata = bus1.rdata;
      @(posedge clk); #1;
      chk("l1_ready_back", 32'(bus1.ready), 32'd1);
      chk("l1_resp_done", 32'(bus1.resp_valid), 32'd0);
   endtask

   logic [31:0] stream_addr [6];
   logic [31:0] rd;
   logic        er;
   int          lt, base_acc, base_rv;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      stream_addr = '{32'h10, 32'h18, 32'h1C, 32'h20, 32'h14, 32'h24};
      reset = 1'b1;
      bus0.cs = 1'b0; bus0.rd_wr = 1'b0; bus0.mask = '0; bus0.addr = '0; bus0.wdata = '0;
      bus1.cs = 1'b0; bus1.rd_wr = 1'b0; bus1.mask = '0; bus1.addr = '0; bus1.wdata = '0;
      repeat (2) @(posedge clk);
      // cs during reset must be ignored
      bus0.cs = 1'b1;
      @(posedge clk); #1;
      chk("reset_ready", 32'(bus0.ready), 32'd1);
      chk("reset_rv", 32'(bus0.resp_valid), 32'd0);
      @(negedge clk);
      bus0.cs = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      chk("reset_no_accept", 32'(n_acc), 32'd0);

      // Full write then read
      do_req(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rd, er, lt);
      chk("wr_latency", 32'(lt), 32'd2);
      chk("wr_rdata_zero", rd, 32'd0);
      chk("wr_err", 32'(er), 32'd0);
      do_req(1'b0, 4'hF, 32'h10, 32'h0, rd, er, lt);
      chk("rd_latency", 32'(lt), 32'd2);
      chk("rd_data", rd, 32'hDEADBEEF);
      chk("rd_err", 32'(er), 32'd0);

      // Single-lane write
      do_req(1'b1, 4'b0001, 32'h10, 32'h000000AA, rd, er, lt);
      do_req(1'b0, 4'b0000, 32'h10, 32'h0, rd, er, lt);
      chk("lane0_data", rd, 32'hDEADBEAA);

      // Empty mask writes nothing but still responds
      do_req(1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF, rd, er, lt);
      chk("mask0_latency", 32'(lt), 32'd2);
      do_req(1'b0, 4'hF, 32'h10, 32'h0, rd, er, lt);
      chk("mask0_data", rd, 32'hDEADBEAA);

      // Upper-half write
      do_req(1'b1, 4'hF, 32'h14, 32'h01234567, rd, er, lt);
      do_req(1'b1, 4'b1100, 32'h14, 32'hABCD0000, rd, er, lt);
      do_req(1'b0, 4'hF, 32'h14, 32'h0, rd, er, lt);
      chk("upper_data", rd, 32'hABCD4567);

      // cs held for 6 cycles with a changing address
      @(negedge clk);
      base_acc = n_acc;
      base_rv  = rv_count;
      bus0.cs = 1'b1; bus0.rd_wr = 1'b0; bus0.mask = 4'hF;
      for (int i = 0; i < 6; i++) begin
         bus0.addr = stream_addr[i];
         @(posedge clk); #1;
      end
      bus0.cs = 1'b0;
      repeat (LAT + 3) @(posedge clk);
      #1;
      chk("stream_accepts", 32'(n_acc - base_acc), 32'd2);
      chk("stream_responses", 32'(rv_count - base_rv), 32'd2);

      // Reset during WAIT discards a pending write
      do_req(1'b1, 4'hF, 32'h20, 32'hCAFEF00D, rd, er, lt);
      @(negedge clk);
      base_acc = n_acc;
      base_rv  = rv_count;
      bus0.cs = 1'b1; bus0.rd_wr = 1'b1; bus0.mask = 4'hF; bus0.addr = 32'h20; bus0.wdata = 32'h12345678;
      @(posedge clk); #1;
      bus0.cs = 1'b0;
      chk("abort_accepted", 32'(n_acc - base_acc), 32'd1);
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk("abort_rv_low", 32'(bus0.resp_valid), 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("abort_no_resp", 32'(rv_count - base_rv), 32'd0);
      do_req(1'b0, 4'hF, 32'h20, 32'h0, rd, er, lt);
      chk("abort_data", rd, 32'hCAFEF00D);

      // Address 0x402: wraps to word 0, or errors when checking is enabled
      do_req(1'b1, 4'hF, 32'h0, 32'h11111111, rd, er, lt);
      do_req(1'b1, 4'hF, 32'h402, 32'h55AA55AA, rd, er, lt);
`ifdef DMEM_ERR_EN
      chk("oor_wr_err", 32'(er), 32'd1);
`else
      chk("wrap_wr_err", 32'(er), 32'd0);
`endif
      do_req(1'b0, 4'hF, 32'h0, 32'h0, rd, er, lt);
`ifdef DMEM_ERR_EN
      chk("oor_word0", rd, 32'h11111111);
`else
      chk("wrap_word0", rd, 32'h55AA55AA);
`endif

      // Misaligned full-word write and out-of-range read
      do_req(1'b1, 4'hF, 32'h33, 32'h0BADC0DE, rd, er, lt);
`ifdef DMEM_ERR_EN
      chk("misalign_err", 32'(er), 32'd1);
`else
      chk("misalign_noerr", 32'(er), 32'd0);
      do_req(1'b0, 4'hF, 32'h30, 32'h0, rd, er, lt);
      chk("misalign_word12", rd, 32'h0BADC0DE);
`endif
      do_req(1'b0, 4'hF, 32'h400, 32'h0, rd, er, lt);
`ifdef DMEM_ERR_EN
      chk("oor_rd_err", 32'(er), 32'd1);
      chk("oor_rd_zero", rd, 32'd0);
`else
      chk("wrap_rd_err", 32'(er), 32'd0);
      chk("wrap_rd_data", rd, 32'h55AA55AA);
`endif

      // LATENCY=1 instance
      do_req1(1'b1, 32'h40, 32'h13572468, rd);
      chk("l1_wr_rdata", rd, 32'd0);
      do_req1(1'b0, 32'h40, 32'h0, rd);
      chk("l1_rd_data", rd, 32'h13572468);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
